// File: rtl/move_scheduler.sv
// Queued motion-segment scheduler: a FIFO of segments is replayed as DDA tick strobes at a divided clock rate.
// Optional feature: define MOVE_SCHEDULER_ABORT_EN to add an abort input that flushes the queue and the active segment.
module move_scheduler #(
  parameter int DEPTH = 4,
  parameter int DIV_W = 24
) (
  input  logic                     CLK,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [DIV_W-1:0]         clock_divisor,
`ifdef MOVE_SCHEDULER_ABORT_EN
  input  logic                     abort,
`endif
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic                     push_dir,
  input  logic [63:0]              push_duration,
  input  logic signed [63:0]       push_increment,
  input  logic signed [63:0]       push_incinc,
  output logic                     seg_load,
  output logic                     seg_dir,
  output logic signed [63:0]       seg_increment,
  output logic signed [63:0]       seg_incinc,
  output logic                     dda_tick,
  output logic [63:0]              tick_remaining,
  output logic                     busy,
  output logic                     move_done,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  // A programmed divisor of zero behaves as one tick per cycle.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  logic                    mem_dir    [DEPTH];
  logic [63:0]             mem_dur    [DEPTH];
  logic signed [63:0]      mem_inc    [DEPTH];
  logic signed [63:0]      mem_incinc [DEPTH];

  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [FILL_W-1:0]       r_fill;

  state_t                  r_state;
  logic                    r_busy;
  logic                    r_seg_load;
  logic                    r_seg_dir;
  logic signed [63:0]      r_seg_inc;
  logic signed [63:0]      r_seg_incinc;
  logic                    r_tick;
  logic [63:0]             r_remaining;
  logic [DIV_W-1:0]        r_cnt;
  logic                    r_done;
  logic                    r_underrun;

  logic                    w_abort;
  logic                    w_push;
  logic                    w_pop;
  logic [DIV_W-1:0]        w_div;
  logic [DIV_W:0]          w_cnt_inc;
  logic                    w_tick_due;

`ifdef MOVE_SCHEDULER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign push_ready = (r_fill < FILL_W'(DEPTH)) && !w_abort;
  assign w_push     = push_valid && push_ready;
  assign w_pop      = (r_state == S_LOAD) && !w_abort;
  assign w_div      = eff_div(clock_divisor);
  assign w_cnt_inc  = {1'b0, r_cnt} + 1'b1;
  // Compare against counter+1 so a divisor lowered below the count fires at once.
  assign w_tick_due = w_cnt_inc >= {1'b0, w_div};

  // Segment storage carries no reset; validity is tracked by fill.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      mem_dir[r_wr_ptr]    <= push_dir;
      mem_dur[r_wr_ptr]    <= push_duration;
      mem_inc[r_wr_ptr]    <= push_increment;
      mem_incinc[r_wr_ptr] <= push_incinc;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else if (w_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_seg_load   <= 1'b0;
      r_seg_dir    <= 1'b0;
      r_seg_inc    <= '0;
      r_seg_incinc <= '0;
      r_tick       <= 1'b0;
      r_remaining  <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_seg_load <= 1'b0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
      if (w_abort) begin
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_remaining <= '0;
        r_cnt       <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (enable && (r_fill != '0)) begin
              r_state <= S_LOAD;
              r_busy  <= 1'b1;
            end
          end
          S_LOAD: begin
            r_seg_dir    <= mem_dir[r_rd_ptr];
            r_seg_inc    <= mem_inc[r_rd_ptr];
            r_seg_incinc <= mem_incinc[r_rd_ptr];
            r_remaining  <= mem_dur[r_rd_ptr];
            r_cnt        <= '0;
            r_seg_load   <= 1'b1;
            r_state      <= S_RUN;
          end
          S_RUN: begin
            // Completion does not wait for enable; only the next load does.
            if (r_remaining == '0) begin
              r_done <= 1'b1;
              if (r_fill == '0) r_underrun <= 1'b1;
              if (enable && (r_fill != '0)) begin
                r_state <= S_LOAD;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else if (enable) begin
              if (w_tick_due) begin
                r_tick      <= 1'b1;
                r_cnt       <= '0;
                r_remaining <= r_remaining - 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign seg_load       = r_seg_load;
  assign seg_dir        = r_seg_dir;
  assign seg_increment  = r_seg_inc;
  assign seg_incinc     = r_seg_incinc;
  assign dda_tick       = r_tick;
  assign tick_remaining = r_remaining;
  assign busy           = r_busy;
  assign move_done      = r_done;
  assign underrun       = r_underrun;
  assign fill           = r_fill;

endmodule
